// File: rtl/risc_pkg.sv
// risc_pkg
// Shared definitions for the instruction-path blocks: default widths and
// depth, the burst-loader state encoding and the terminator instruction.
package risc_pkg;

  localparam int DEF_INST_W = 8;
  localparam int DEF_BUS_W  = 256;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic {
    LD_IDLE   = 1'b0,
    LD_UNPACK = 1'b1
  } ld_state_e;

  // All-ones instruction; ends unpacking early when the terminator stop is enabled.
  localparam logic [DEF_INST_W-1:0] INST_TERM = '1;

endpackage

// File: rtl/inst_ram.sv
// inst_ram
// DEPTH x INST_W instruction store, one write port and one read port,
// synchronous read, no reset on the contents.
//   clk            sole clock, rising edge
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr  read request; rd_data is valid the cycle after rd_en
//   rd_data        registered read data (held when rd_en is low)
module inst_ram #(
  parameter int INST_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_stream_loader.sv
// inst_stream_loader
// Instruction memory with a burst loader. A wide bus word is captured on
// load accept and unpacked into consecutive slots, one lane per cycle,
// starting at load_base (wrapping mod DEPTH). The execution engine reads
// through a request/valid port with one cycle of latency, served only while
// the loader is idle.
//   clk, nReset                         clock, async active-low reset
//   load_valid/load_ready/load_data/load_base   load handshake and payload
//   load_done                           one-cycle pulse after the final write
//   clear                               synchronous zero of prog_len
//   fetch_req/fetch_addr                read request
//   fetch_valid/fetch_data/fetch_oob    read response
//   prog_len                            instructions written, saturating at DEPTH
//
// state     | meaning
// ----------+---------------------------------------------------------
// LD_IDLE   | ready for a load; fetch requests are served
// LD_UNPACK | writing captured lanes, one per cycle; fetches are dropped
module inst_stream_loader
  import risc_pkg::*;
#(
  parameter int BUS_W   = DEF_BUS_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TERM_EN = 0,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [BUS_W-1:0]  load_data,
  input  logic [ADDR_W-1:0] load_base,
  output logic              load_done,
  input  logic              clear,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [INST_W-1:0] fetch_data,
  output logic              fetch_oob,
  output logic [LEN_W-1:0]  prog_len
);

  localparam int LANES  = BUS_W / INST_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [INST_W-1:0] TERM_INST = {INST_W{INST_TERM[0]}};

  ld_state_e                    state_q, state_d;
  logic [LANE_W-1:0]            lane_q, lane_d;
  logic [LANES-1:0][INST_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0]            base_q, base_d;
  logic [LEN_W-1:0]             len_q, len_d;
  logic                         done_q, done_d;
  logic                         fvalid_q, fvalid_d;
  logic                         foob_q, foob_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [INST_W-1:0] wr_inst;
  logic              rd_en;
  logic [INST_W-1:0] rd_inst;
  logic              last_lane;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    word_d    = word_q;
    base_d    = base_q;
    len_d     = len_q;
    done_d    = 1'b0;
    fvalid_d  = 1'b0;
    foob_d    = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    wr_addr   = base_q + ADDR_W'(lane_q);
    wr_inst   = word_q[lane_q];
    last_lane = (lane_q == LANE_LAST) || ((TERM_EN != 0) && (wr_inst == TERM_INST));

    case (state_q)
      LD_IDLE: begin
        if (load_valid) begin
          state_d = LD_UNPACK;
          lane_d  = '0;
          word_d  = load_data;
          base_d  = load_base;
        end
        // A fetch on the accept edge reads the RAM before lane 0 lands.
        if (fetch_req) begin
          rd_en    = 1'b1;
          fvalid_d = 1'b1;
          foob_d   = (LEN_W'(fetch_addr) >= len_q);
        end
      end
      LD_UNPACK: begin
        wr_en = 1'b1;
        if (len_q != LEN_MAX) len_d = len_q + 1'b1;
        if (last_lane) begin
          state_d = LD_IDLE;
          done_d  = 1'b1;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase

    if (clear) len_d = '0;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= LD_IDLE;
      lane_q   <= '0;
      word_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      fvalid_q <= 1'b0;
      foob_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      base_q   <= base_d;
      len_q    <= len_d;
      done_q   <= done_d;
      fvalid_q <= fvalid_d;
      foob_q   <= foob_d;
    end
  end

  inst_ram #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_inst),
    .rd_en   (rd_en),
    .rd_addr (fetch_addr),
    .rd_data (rd_inst)
  );

  assign load_ready  = (state_q == LD_IDLE);
  assign load_done   = done_q;
  assign prog_len    = len_q;
  assign fetch_valid = fvalid_q;
  assign fetch_oob   = foob_q;
  // RAM output is unreset and holds stale data; expose it only on an in-range response.
  assign fetch_data  = (fvalid_q && !foob_q) ? rd_inst : '0;

endmodule

// File: tb/tb_inst_stream_loader.sv
module tb_inst_stream_loader;

  logic        clk;
  logic        nReset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [3:0]  load_base;
  logic        load_done;
  logic        clear;
  logic        fetch_req;
  logic [3:0]  fetch_addr;
  logic        fetch_valid;
  logic [7:0]  fetch_data;
  logic        fetch_oob;
  logic [4:0]  prog_len;

  inst_stream_loader #(
    .BUS_W   (32),
    .INST_W  (8),
    .DEPTH   (16),
    .TERM_EN (1)
  ) dut (
    .clk         (clk),
    .nReset      (nReset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_base   (load_base),
    .load_done   (load_done),
    .clear       (clear),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_oob   (fetch_oob),
    .prog_len    (prog_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    bit         v;
    logic       oob;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mm [16];
  int         mlen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [3:0] a, input bit v);
    exp_t e;
    e.v    = v;
    e.oob  = (int'(a) >= mlen);
    e.data = e.oob ? 8'h00 : mm[a];
    exp_q.push_back(e);
  endtask

  bit   mon_req;
  exp_t mon_e;
  always @(posedge clk) begin
    mon_req = fetch_req && nReset;
    #1;
    if (mon_req) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fetch_valid", fetch_valid, mon_e.v);
        if (mon_e.v) begin
          chk("fetch_oob", fetch_oob, mon_e.oob);
          chk("fetch_data", fetch_data, mon_e.data);
        end
      end
    end
  end

  task automatic fetch_seq(input logic [3:0] a0, input int cnt);
    logic [3:0] a;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      a          = a0 + 4'(i);
      fetch_req  = 1'b1;
      fetch_addr = a;
      push_fetch(a, 1'b1);
    end
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  // Accept one bus word and follow it to load_done, updating the model per write edge.
  task automatic do_load(input logic [31:0] d, input logic [3:0] b, input int exp_n,
                         input bit f0, input bit fmid, input int clr_at);
    int         n;
    bit         got;
    logic [3:0] idx;
    @(negedge clk);
    chk("load_ready_pre", load_ready, 1);
    load_valid = 1'b1;
    load_data  = d;
    load_base  = b;
    if (f0) begin
      fetch_req  = 1'b1;
      fetch_addr = 4'd0;
      push_fetch(4'd0, 1'b1);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 32'hFFFF_FFFF;
    fetch_req  = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      if (n == 0 && fmid) begin
        fetch_req  = 1'b1;
        fetch_addr = 4'd2;
        push_fetch(4'd2, 1'b0);
      end
      clear = (clr_at == n + 1);
      @(posedge clk);
      #1;
      n++;
      if (n <= exp_n) begin
        idx     = b + 4'(n - 1);
        mm[idx] = d[(n-1)*8 +: 8];
        mlen    = (n == clr_at) ? 0 : ((mlen < 16) ? mlen + 1 : 16);
      end
      if (n == clr_at) chk("clear_len", prog_len, 0);
      if (load_done) got = 1'b1;
      else begin
        @(negedge clk);
        fetch_req = 1'b0;
        clear     = 1'b0;
      end
    end
    chk("done_latency", n, exp_n);
    chk("ready_at_done", load_ready, 1);
    @(negedge clk);
    fetch_req = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_base  = '0;
    clear      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_fetch_oob", fetch_oob, 0);
    chk("rst_prog_len", prog_len, 0);
    nReset = 1'b1;

    // basic load at base 0, fetch back plus one out-of-range address
    do_load(32'h4433_2211, 4'd0, 4, 1'b0, 1'b0, -1);
    chk("len_t1", prog_len, 4);
    fetch_seq(4'd0, 5);

    // wrap-around load
    do_load(32'hDDCC_BBAA, 4'd14, 4, 1'b0, 1'b0, -1);
    chk("len_t2", prog_len, 8);
    fetch_seq(4'd14, 4);

    // give slot 7 a known value, then terminator load leaves it alone
    do_load(32'h0B0A_0908, 4'd4, 4, 1'b0, 1'b0, -1);
    chk("len_prep", prog_len, 12);
    do_load(32'h77FF_6655, 4'd4, 3, 1'b0, 1'b0, -1);
    chk("len_t3", prog_len, 15);
    fetch_seq(4'd4, 4);

    // fetch on accept edge returns old slot 0; fetch during unpack is dropped
    do_load(32'h0403_0201, 4'd0, 4, 1'b1, 1'b1, -1);
    chk("len_t4", prog_len, 16);
    fetch_seq(4'd0, 1);

    // reset in the second unpack cycle
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'h5A5B_5C5D;
    load_base  = 4'd8;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    nReset = 1'b0;
    #1;
    chk("rst_mid_ready", load_ready, 1);
    chk("rst_mid_len", prog_len, 0);
    chk("rst_mid_done", load_done, 0);
    mm[8] = 8'h5D;
    mlen  = 0;
    @(negedge clk);
    nReset = 1'b1;

    // saturation over five loads, then clear colliding with a write
    for (int i = 0; i < 5; i++) begin
      do_load({8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)}, 4'd12, 4,
              1'b0, 1'b0, -1);
      chk("len_sat", prog_len, ((i + 1) * 4 > 16) ? 16 : (i + 1) * 4);
    end
    fetch_seq(4'd8, 1);
    fetch_seq(4'd12, 4);
    do_load(32'h0807_0605, 4'd0, 4, 1'b0, 1'b0, 2);
    chk("len_after_clear", prog_len, 2);
    fetch_seq(4'd0, 3);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
